// File: rtl/display_pkg.sv
// Shared types and constants for the GPIO seven-segment display block.
//   state_t      : conversion engine states (IDLE, SHIFT, DONE)
//   SEG_BLANK    : all segments off (active-low)
//   SEG_DASH     : only segment g lit, shown on decimal overflow
//   NUM_DIGITS   : number of physical displays
//   BCD_DIGITS   : BCD accumulator width in digits (covers 2^32-1)
//   CONV_CYCLES  : one shift per input bit
package display_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [6:0] SEG_BLANK   = 7'h7F;
  localparam logic [6:0] SEG_DASH    = 7'b0111111;
  localparam int         NUM_DIGITS  = 8;
  localparam int         BCD_DIGITS  = 10;
  localparam int         CONV_CYCLES = 32;

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble to seven-segment decoder.
//   nibble : 4-bit hex digit
//   seg    : {g,f,e,d,c,b,a}, active-low
module seg7_decode (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'b1111111;
    unique case (nibble)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/gpio_display.sv
// Drives eight active-low seven-segment displays from the CPU gpio word.
// The word is shown either as 8 hex digits or as an unsigned decimal
// number produced by a bit-serial double-dabble engine (one bit per clock).
// Both modes take the same number of cycles so display latency is fixed.
//   clk, reset   : clock, synchronous active-high reset
//   value        : 32-bit word to display
//   hex_mode     : 1 = hexadecimal, 0 = unsigned decimal
//   busy         : conversion in progress
//   overflow     : decimal value does not fit in 8 digits
//   hex0..hex7   : segment patterns {g,f,e,d,c,b,a}, hex0 least significant
module gpio_display
  import display_pkg::*;
#(
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] value,
  input  logic        hex_mode,
  output logic        busy,
  output logic        overflow,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5,
  output logic [6:0]  hex6,
  output logic [6:0]  hex7
);

  // Adds 3 to every BCD digit that is 5 or more, ahead of the left shift.
  function automatic logic [4*BCD_DIGITS-1:0] bcd_adjust(input logic [4*BCD_DIGITS-1:0] b);
    logic [4*BCD_DIGITS-1:0] r;
    r = b;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  logic [31:0]             value_q;
  logic                    mode_q;
  state_t                  state;
  logic [31:0]             cap_val;
  logic                    cap_mode;
  logic                    first_pass;
  logic [4:0]              cnt;
  logic [4*BCD_DIGITS-1:0] bcd;
  logic [31:0]             shreg;
  logic [6:0]              hex_r     [NUM_DIGITS];
  logic [3:0]              nib       [NUM_DIGITS];
  logic [6:0]              seg       [NUM_DIGITS];
  logic [6:0]              disp_next [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   lead_zero;
  logic                    zero_run;
  logic                    dec_ovf;

  assign dec_ovf = (bcd[4*BCD_DIGITS-1:4*NUM_DIGITS] != '0);

  // Digit source: captured word in hex mode, finished accumulator otherwise.
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      nib[i] = cap_mode ? cap_val[4*i +: 4] : bcd[4*i +: 4];
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    seg7_decode u_dec (
      .nibble (nib[g]),
      .seg    (seg[g])
    );
  end

  // A digit is a leading zero when it and every more significant digit are
  // zero; the least significant digit is never treated as one.
  always_comb begin
    lead_zero = '0;
    zero_run  = 1'b1;
    for (int i = NUM_DIGITS-1; i >= 1; i--) begin
      zero_run     = zero_run && (bcd[4*i +: 4] == 4'd0);
      lead_zero[i] = zero_run;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (cap_mode)                      disp_next[i] = seg[i];
      else if (dec_ovf)                  disp_next[i] = SEG_DASH;
      else if (BLANK_LZ && lead_zero[i]) disp_next[i] = SEG_BLANK;
      else                               disp_next[i] = seg[i];
    end
  end

  always_ff @(posedge clk) begin
    value_q <= value;
    mode_q  <= hex_mode;
    if (reset) begin
      state      <= IDLE;
      cap_val    <= '0;
      cap_mode   <= 1'b0;
      first_pass <= 1'b1;
      cnt        <= '0;
      overflow   <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) hex_r[i] <= SEG_BLANK;
    end else begin
      unique case (state)
        IDLE: begin
          if (first_pass || ({value_q, mode_q} != {cap_val, cap_mode})) begin
            cap_val    <= value_q;
            cap_mode   <= mode_q;
            shreg      <= value_q;
            bcd        <= '0;
            cnt        <= '0;
            first_pass <= 1'b0;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          {bcd, shreg} <= {bcd_adjust(bcd), shreg} << 1;
          cnt          <= cnt + 5'd1;
          if (cnt == 5'(CONV_CYCLES-1)) state <= DONE;
        end
        DONE: begin
          for (int i = 0; i < NUM_DIGITS; i++) hex_r[i] <= disp_next[i];
          overflow <= cap_mode ? 1'b0 : dec_ovf;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign hex0 = hex_r[0];
  assign hex1 = hex_r[1];
  assign hex2 = hex_r[2];
  assign hex3 = hex_r[3];
  assign hex4 = hex_r[4];
  assign hex5 = hex_r[5];
  assign hex6 = hex_r[6];
  assign hex7 = hex_r[7];

endmodule
